clkdiv: RTL and testbench

- Programmable clock divider / clock-enable generator that consumes the bench clock.
- It produces a registered, glitch-free divided clock (clk_out) and a one-cycle tick strobe at the start of each divided period.
- Used by testbenches and models that need slower derived clocks or rate strobes without instantiating another free-running generator.
- Divide ratio is changeable at run time. A change takes effect only on a period boundary, under a load/ack handshake.

---
 rtl/clkdiv_pkg.sv | 19 +
 rtl/clkdiv.sv | 134 +++++++++++++
 tb/tb_clkdiv.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
//   state_t   : divider run state (IDLE / RUN / STOP_PEND)
//   MIN_DIV   : smallest legal divide ratio
//   high_len  : number of high cycles in a period of ratio n (ceil(n/2))
package clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_t;

  localparam int MIN_DIV = 2;

  function automatic int unsigned high_len(input int unsigned n);
    return n - n / 2;
  endfunction

endpackage

// File: rtl/clkdiv.sv
// Programmable clock divider / clock-enable generator.
// Produces a registered divided clock and a one-cycle tick at the start of
// every divided period. The ratio can be reloaded at run time; a reload
// while running waits for the period boundary and is acknowledged there.
//
// Ports:
//   clk, rst_n        input clock, synchronous active-low reset
//   en                level-sensitive run request
//   div_val/div_load  requested ratio and its one-cycle load strobe
//   div_ack           pulse when a new ratio takes effect
//   div_err           pulse when a requested ratio (0 or 1) is rejected
//   div_pend          a legal load is waiting for a period boundary
//   div_cur           ratio currently in force
//   clk_out, tick     divided clock and period-start strobe
//   running           divider is in RUN or STOP_PEND
//   tick_cnt          number of ticks issued, wrapping
module clkdiv
  import clkdiv_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 2,
  parameter int TICK_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  div_val,
  input  logic              div_load,
  output logic              div_ack,
  output logic              div_err,
  output logic              div_pend,
  output logic [CNT_W-1:0]  div_cur,
  output logic              clk_out,
  output logic              tick,
  output logic              running,
  output logic [TICK_W-1:0] tick_cnt
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] div_nx;
  logic [CNT_W-1:0] pend_val, pend_val_nx;
  logic             pend_nx;
  logic             ack_nx, err_nx;
  logic             wrap;
  logic             active_nx, tick_nx, clk_nx;
  logic [31:0]      hl_nx;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    div_nx      = div_cur;
    pend_nx     = div_pend;
    pend_val_nx = pend_val;
    ack_nx      = 1'b0;
    err_nx      = 1'b0;

    // Last cycle of the current period (only meaningful while active).
    wrap = (state != IDLE) && (cnt == div_cur - CNT_W'(1));

    if (state == IDLE) begin
      cnt_nx = '0;
      // A load accepted on the very boundary that stopped the divider is
      // left pending; there is no further boundary in IDLE, so apply it now.
      if (div_pend) begin
        div_nx  = pend_val;
        pend_nx = 1'b0;
        ack_nx  = 1'b1;
      end
      if (en) state_nx = RUN;
    end else if (wrap) begin
      cnt_nx   = '0;
      state_nx = en ? RUN : IDLE;
      if (div_pend) begin
        div_nx  = pend_val;
        pend_nx = 1'b0;
        ack_nx  = 1'b1;
      end
    end else begin
      cnt_nx   = cnt + CNT_W'(1);
      state_nx = en ? RUN : STOP_PEND;
    end

    // Load handling comes after the boundary logic so a load arriving on a
    // wrap is held for the following boundary.
    if (div_load) begin
      if (div_val < CNT_W'(MIN_DIV)) begin
        err_nx = 1'b1;
      end else if (state == IDLE) begin
        div_nx  = div_val;
        pend_nx = 1'b0;
        ack_nx  = 1'b1;
      end else begin
        pend_nx     = 1'b1;
        pend_val_nx = div_val;
      end
    end

    // Outputs are registered from next-state values so they line up with cnt.
    active_nx = (state_nx != IDLE);
    hl_nx     = high_len(32'(div_nx));
    tick_nx   = active_nx && (cnt_nx == '0);
    clk_nx    = active_nx && (32'(cnt_nx) < hl_nx);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      div_cur  <= CNT_W'(DEF_DIV);
      pend_val <= '0;
      div_pend <= 1'b0;
      div_ack  <= 1'b0;
      div_err  <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      running  <= 1'b0;
      tick_cnt <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      div_cur  <= div_nx;
      pend_val <= pend_val_nx;
      div_pend <= pend_nx;
      div_ack  <= ack_nx;
      div_err  <= err_nx;
      clk_out  <= clk_nx;
      tick     <= tick_nx;
      running  <= active_nx;
      if (tick_nx) tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

endmodule

// File: tb/tb_clkdiv.sv
// Self-checking bench for clkdiv: directed scenarios followed by random
// traffic, compared cycle by cycle against a period-level reference model.
module tb_clkdiv;

  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 2;
  localparam int TICK_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [CNT_W-1:0]  div_val = '0;
  logic              div_load = 1'b0;
  logic              div_ack, div_err, div_pend;
  logic [CNT_W-1:0]  div_cur;
  logic              clk_out, tick, running;
  logic [TICK_W-1:0] tick_cnt;

  clkdiv #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV), .TICK_W(TICK_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_val(div_val), .div_load(div_load),
    .div_ack(div_ack), .div_err(div_err), .div_pend(div_pend),
    .div_cur(div_cur), .clk_out(clk_out), .tick(tick), .running(running),
    .tick_cnt(tick_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: "on" means a period is in progress (running), pos is
  // the position inside the current period, n the ratio in force.
  bit m_on = 0, m_pp = 0;
  int m_pos = 0, m_n = DEF_DIV, m_pv = 0, m_tcnt = 0;
  bit e_ack = 0, e_err = 0, e_tick = 0, e_clk = 0;

  task automatic model_step(input bit r, input bit e, input bit ld, input int v);
    bit was_on;
    if (!r) begin
      m_on = 0; m_pp = 0; m_pos = 0; m_n = DEF_DIV; m_tcnt = 0;
      e_ack = 0; e_err = 0; e_tick = 0; e_clk = 0;
      return;
    end
    was_on = m_on;
    e_ack = 0; e_err = 0;
    if (m_on) begin
      if (m_pos == m_n - 1) begin
        // Period complete: take any pending ratio, keep going only if en.
        m_pos = 0;
        if (m_pp) begin m_n = m_pv; m_pp = 0; e_ack = 1; end
        m_on = e;
      end else begin
        m_pos++;
      end
    end else begin
      if (m_pp) begin m_n = m_pv; m_pp = 0; e_ack = 1; end
      if (e) begin m_on = 1; m_pos = 0; end
    end
    if (ld) begin
      if (v < 2)        e_err = 1;
      else if (!was_on) begin m_n = v; m_pp = 0; e_ack = 1; end
      else              begin m_pv = v; m_pp = 1; end
    end
    e_tick = m_on && (m_pos == 0);
    e_clk  = m_on && (m_pos < m_n - m_n / 2);
    if (e_tick) m_tcnt = (m_tcnt + 1) % (1 << TICK_W);
  endtask

  task automatic check_all();
    chk("clk_out",  32'(clk_out),  32'(e_clk));
    chk("tick",     32'(tick),     32'(e_tick));
    chk("div_ack",  32'(div_ack),  32'(e_ack));
    chk("div_err",  32'(div_err),  32'(e_err));
    chk("div_pend", 32'(div_pend), 32'(m_pp));
    chk("div_cur",  32'(div_cur),  32'(m_n));
    chk("running",  32'(running),  32'(m_on));
    chk("tick_cnt", 32'(tick_cnt), 32'(m_tcnt));
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare.
  task automatic cyc(input bit r, input bit e, input bit ld, input int v);
    rst_n    = r;
    en       = e;
    div_load = ld;
    div_val  = v[CNT_W-1:0];
    @(posedge clk);
    model_step(r, e, ld, v);
    #1;
    check_all();
  endtask

  initial begin
    // Reset state
    repeat (2) cyc(0, 0, 0, 0);

    // Default ratio 2: first tick one cycle after en
    repeat (9) cyc(1, 1, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);

    // Load 5 in IDLE, then run 3-high/2-low periods
    cyc(1, 0, 1, 5);
    repeat (12) cyc(1, 1, 0, 0);
    repeat (6) cyc(1, 0, 0, 0);

    // Ratio 4 running, reload 6 at cnt=1, then 3 and 7 within one period
    cyc(1, 0, 1, 4);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 6);
    repeat (16) cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 3);
    cyc(1, 1, 1, 7);
    repeat (16) cyc(1, 1, 0, 0);

    // Illegal ratios 0 and 1, including while a legal load is pending
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 1);
    cyc(1, 1, 1, 9);
    cyc(1, 1, 1, 0);
    repeat (12) cyc(1, 1, 0, 0);

    // Ratio 4: stop mid-period, then stop and re-raise before the wrap
    repeat (12) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 4);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    repeat (6) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (10) cyc(1, 1, 0, 0);

    // Reset mid-period with a pending load
    cyc(1, 1, 1, 6);
    repeat (8) cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 9);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (4) cyc(1, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bit r, e, ld;
      int v;
      r  = ($urandom_range(0, 199) != 0);
      e  = ($urandom_range(0, 9) < 7);
      ld = ($urandom_range(0, 9) == 0);
      v  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40))
                                        : int'($urandom_range(0, 9));
      cyc(r, e, ld, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
